// File: rtl/univ_shift_pkg.sv
// Shared mode codes, FSM state encoding and mode classification for univ_shift_reg_n.
// Honours UNIV_SHIFT_REG_ROTATE_EN: rotate codes count as multi-step only when it is defined.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_ASHR  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Modes that honour the step count; everything else finishes at the accepting edge.
  function automatic logic is_multi_step(input mode_t m);
    logic r;
    case (m)
      MODE_SHR, MODE_SHL, MODE_ASHR: r = 1'b1;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      MODE_ROR, MODE_ROL:            r = 1'b1;
`endif
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_step_cnt.sv
// Remaining-step counter for univ_shift_reg_n: parallel load, saturating decrement, zero flag.
module shift_step_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  // Counter register; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= {CNT_W{1'b0}};
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != {CNT_W{1'b0}})) begin
      value <= value - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      value <= value;
    end
  end

  assign zero = (value == {CNT_W{1'b0}});

endmodule

// File: rtl/univ_shift_reg_n.sv
// Universal shift register with multi-step shift/rotate operations and busy/done handshake.
// Macro UNIV_SHIFT_REG_ROTATE_EN enables ROR/ROL; when undefined those codes act as HOLD.
module univ_shift_reg_n
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] d,
  input  logic             msb_in,
  input  logic             lsb_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             ser_out
);

  state_t           state, state_next;
  mode_t            cur_mode, eff_mode;
  logic             accept, step_en;
  logic             cnt_load, cnt_dec, cnt_zero, done_next;
  logic [CNT_W-1:0] cnt_val, remaining;
  logic [WIDTH-1:0] q_step;
  logic             ser_step;

  shift_step_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .value    (remaining),
    .zero     (cnt_zero)
  );

  assign busy = (state == ST_RUN);

  // Acceptance and the mode in force this edge: the live input on acceptance, else the latched one.
  always_comb begin
    accept  = start && (state == ST_IDLE);
    step_en = accept || (state == ST_RUN);
    if (accept) begin
      eff_mode = mode_t'(mode);
    end else begin
      eff_mode = cur_mode;
    end
  end

  // Single-step datapath result for the effective mode.
  always_comb begin
    q_step   = q;
    ser_step = ser_out;
    case (eff_mode)
      MODE_HOLD:  q_step = q;
      MODE_SHR:   begin q_step = {msb_in, q[WIDTH-1:1]};   ser_step = q[0];       end
      MODE_SHL:   begin q_step = {q[WIDTH-2:0], lsb_in};   ser_step = q[WIDTH-1]; end
      MODE_LOAD:  q_step = d;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      MODE_ROR:   begin q_step = {q[0], q[WIDTH-1:1]};     ser_step = q[0];       end
      MODE_ROL:   begin q_step = {q[WIDTH-2:0], q[WIDTH-1]}; ser_step = q[WIDTH-1]; end
`endif
      MODE_ASHR:  begin q_step = {q[WIDTH-1], q[WIDTH-1:1]}; ser_step = q[0];     end
      MODE_CLEAR: q_step = {WIDTH{1'b0}};
      default:    q_step = q;
    endcase
  end

  // FSM next state; the counter holds steps still owed after the current edge.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = {CNT_W{1'b0}};
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_multi_step(eff_mode) &&
            (count > {{(CNT_W-1){1'b0}}, 1'b1})) begin
          state_next = ST_RUN;
          cnt_load   = 1'b1;
          cnt_val    = count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (accept) begin
          done_next = 1'b1;
        end else begin
          done_next = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_dec = 1'b1;
        if (cnt_zero || (remaining == {{(CNT_W-1){1'b0}}, 1'b1})) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur_mode <= MODE_HOLD;
      q        <= {WIDTH{1'b0}};
      ser_out  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (accept) begin
        cur_mode <= eff_mode;
      end
      if (step_en) begin
        q       <= q_step;
        ser_out <= ser_step;
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Scoreboard bench for univ_shift_reg_n (WIDTH=4, CNT_W=4): a behavioural model pushes the
// expected outputs for each edge, which are popped and compared one time unit after that edge.
module tb_univ_shift_reg_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mode;
  logic       start;
  logic [3:0] count;
  logic [3:0] d;
  logic       msb_in, lsb_in;
  logic [3:0] q;
  logic       busy, done, ser_out;

  univ_shift_reg_n #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .count(count), .d(d),
    .msb_in(msb_in), .lsb_in(lsb_in), .q(q), .busy(busy), .done(done), .ser_out(ser_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       ser;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0] m_q;
  logic       m_busy, m_done, m_ser;
  logic [2:0] m_mode;
  int         m_rem;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_multi(input logic [2:0] md);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    return (md == 3'd1) || (md == 3'd2) || (md == 3'd6) || (md == 3'd4) || (md == 3'd5);
`else
    return (md == 3'd1) || (md == 3'd2) || (md == 3'd6);
`endif
  endfunction

  task automatic ref_apply(input logic [2:0] md);
    logic [3:0] o;
    o = m_q;
    case (md)
      3'd1: begin m_q = (o >> 1) | {msb_in, 3'b000}; m_ser = o[0]; end
      3'd2: begin m_q = (o << 1) | {3'b000, lsb_in}; m_ser = o[3]; end
      3'd3: m_q = d;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      3'd4: begin m_q = (o >> 1) | {o[0], 3'b000}; m_ser = o[0]; end
      3'd5: begin m_q = (o << 1) | {3'b000, o[3]}; m_ser = o[3]; end
`endif
      3'd6: begin m_q = (o >> 1) | {o[3], 3'b000}; m_ser = o[0]; end
      3'd7: m_q = 4'b0000;
      default: m_q = o;
    endcase
  endtask

  task automatic ref_edge();
    int n;
    if (start && !m_busy) begin
      m_mode = mode;
      ref_apply(mode);
      n = (count == 4'd0) ? 1 : int'(count);
      if (ref_multi(mode) && n > 1) begin
        m_rem  = n - 1;
        m_busy = 1'b1;
        m_done = 1'b0;
      end else begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (m_busy) begin
      ref_apply(m_mode);
      m_rem--;
      m_busy = (m_rem != 0);
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic ref_reset();
    m_q = 4'b0000; m_busy = 1'b0; m_done = 1'b0; m_ser = 1'b0; m_mode = 3'd0; m_rem = 0;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    ref_edge();
    sb.push_back('{q: m_q, busy: m_busy, done: m_done, ser: m_ser});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({tag, "_q"},    32'(q),       32'(e.q));
    check_eq({tag, "_busy"}, 32'(busy),    32'(e.busy));
    check_eq({tag, "_done"}, 32'(done),    32'(e.done));
    check_eq({tag, "_ser"},  32'(ser_out), 32'(e.ser));
  endtask

  task automatic go(input logic [2:0] md, input logic [3:0] cnt, input logic [3:0] dv);
    start = 1'b1; mode = md; count = cnt; d = dv;
  endtask

  initial begin
    reset = 1'b1; mode = 3'd0; start = 1'b0; count = 4'd0; d = 4'd0;
    msb_in = 1'b0; lsb_in = 1'b0;
    ref_reset();
    #12;
    check_eq("rst_q", 32'(q), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_ser", 32'(ser_out), 32'h0);
    reset = 1'b0;

    // LOAD then idle
    go(3'd3, 4'd0, 4'b0101); tick("load");
    start = 1'b0; tick("load_idle");

    // SHR count=3 with msb_in=1
    go(3'd1, 4'd3, 4'b0000); msb_in = 1'b1; tick("shr1");
    start = 1'b0; tick("shr2"); tick("shr3"); tick("shr_idle");
    check_eq("shr_final_q", 32'(q), 32'hE);
    check_eq("shr_final_ser", 32'(ser_out), 32'h1);

    // ROL count=4 from 1001, with an ignored start during busy when rotates exist
    go(3'd3, 4'd0, 4'b1001); tick("load2");
    go(3'd5, 4'd4, 4'b0000); tick("rol1");
    for (int i = 0; i < 4; i++) begin
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      start = (i == 1); mode = 3'd7;
`else
      start = 1'b0;
`endif
      tick("rol_n");
    end
    check_eq("rol_final_q", 32'(q), 32'h9);

    // ASHR count=2 from 1000, then back-to-back SHL count=0
    go(3'd3, 4'd0, 4'b1000); tick("load3");
    start = 1'b0; tick("load3_idle");
    go(3'd6, 4'd2, 4'b0000); tick("ashr1");
    start = 1'b0; tick("ashr2");
    go(3'd2, 4'd0, 4'b0000); lsb_in = 1'b1; tick("shl_b2b");
    start = 1'b0; tick("shl_idle");
    check_eq("shl_final_q", 32'(q), 32'hD);

    // Random operations
    for (int i = 0; i < 80; i++) begin
      start  = 1'($urandom_range(0, 1));
      mode   = 3'($urandom_range(0, 7));
      count  = 4'($urandom_range(0, 15));
      d      = 4'($urandom_range(0, 15));
      msb_in = 1'($urandom_range(0, 1));
      lsb_in = 1'($urandom_range(0, 1));
      tick("rnd");
    end
    start = 1'b0;
    while (m_busy) tick("drain");
    tick("drain_idle");

    // Reset between edges in the middle of a long SHR
    go(3'd3, 4'd0, 4'b0011); tick("load4");
    go(3'd1, 4'd8, 4'b0000); msb_in = 1'b1; tick("shr8_1");
    start = 1'b0; tick("shr8_2"); tick("shr8_3");
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_q", 32'(q), 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'h0);
    check_eq("midrst_done", 32'(done), 32'h0);
    check_eq("midrst_ser", 32'(ser_out), 32'h0);
    ref_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    go(3'd3, 4'd0, 4'b0110); tick("load5");
    start = 1'b0; tick("load5_idle");
    check_eq("post_rst_q", 32'(q), 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_n.md
UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (>=2).
REQ-002 Parameter CNT_W, default 4, width of the step-count field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 mode  input  3  operation code, sampled only when a start is accepted.
REQ-006 start  input  1  request to begin an operation.
REQ-007 count  input  CNT_W  number of shift steps, sampled only when a start is accepted.
REQ-008 d  input  WIDTH  parallel load data, sampled only when a start is accepted.
REQ-009 msb_in  input  1  serial input entering the MSB on right shift, sampled on every step.
REQ-010 lsb_in  input  1  serial input entering the LSB on left shift, sampled on every step.
REQ-011 q  output  WIDTH  register contents.
REQ-012 busy  output  1  multi-step operation in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 ser_out  output  1  bit shifted or rotated out by the most recent step.

Function
REQ-015 Mode codes: 000 hold; 001 SHR (msb_in->MSB); 010 SHL (lsb_in->LSB); 011 LOAD d; 100 ROR; 101 ROL; 110 ASHR (MSB replicated); 111 CLEAR (q=0).
REQ-016 Start is accepted on a rising edge with start=1 and busy=0; start while busy=1 is ignored with no side effect.
REQ-017 The accepting edge applies the first step, giving zero-cycle latency from acceptance to the first q change.
REQ-018 HOLD, LOAD and CLEAR complete at the accepting edge regardless of count.
REQ-019 Shift/rotate modes perform max(count,1) steps, one per edge; count=0 is treated as 1.
REQ-020 When more than one step is needed, busy=1 from the accepting edge until the edge applying the final step, where busy returns to 0.
REQ-021 done=1 for exactly one cycle after the edge applying the final step (or the single step); busy and done are never both 1.
REQ-022 A start with done=1 and busy=0 is accepted, so back-to-back operations run with no idle cycle.
REQ-023 Two-state FSM: IDLE (busy=0) and RUN (busy=1); IDLE->RUN on an accepted start with remaining steps >0; RUN->IDLE when the remaining-step counter reaches 0.
REQ-024 ser_out updates on every shift/rotate step: old q[0] for SHR/ROR/ASHR, old q[WIDTH-1] for SHL/ROL; it is unchanged by HOLD, LOAD and CLEAR.
REQ-025 The remaining-step counter is CNT_W bits wide and never wraps; the maximum run is 2^CNT_W-1 steps.

Reset
REQ-026 Asserting reset immediately forces q=0, busy=0, done=0, ser_out=0, FSM=IDLE, remaining=0, independent of clk.
REQ-027 Reset during RUN discards all pending steps; the first start after release behaves as from power-up.

Configuration
REQ-028 Macro UNIV_SHIFT_REG_ROTATE_EN defined: ROR/ROL behave as in REQ-015.
REQ-029 Macro UNIV_SHIFT_REG_ROTATE_EN undefined: codes 100/101 execute as HOLD (single-edge completion, done pulse, q and ser_out unchanged), and no rotate logic is built.

Structure
REQ-030 Package univ_shift_pkg holds the mode-code constants and the FSM state encoding.
REQ-031 Sub-module shift_step_cnt (load, decrement, zero flag, CNT_W parameter) holds the remaining-step counter; the datapath and FSM stay in univ_shift_reg_n.

Verification (WIDTH=4, CNT_W=4)
REQ-032 LOAD d=0101 -> q=0101 after the accepting edge, done=1 for one cycle, busy stays 0.
REQ-033 q=0101, SHR count=3, msb_in=1 -> q=1010, 1101, 1110 on successive edges; busy=1 for 2 cycles; done pulse follows; ser_out=1.
REQ-034 q=1001, ROL count=4 (macro defined) -> q returns to 1001 after 4 edges; start pulsed during busy is ignored; macro undefined -> q stays 1001 with an immediate done.
REQ-035 q=1000, ASHR count=2 -> q=1100 then 1110; SHL count=0 with lsb_in=1 -> a single step, q=1101.
REQ-036 Reset asserted between clock edges mid-SHR count=8 -> q=0, busy=0, done=0 immediately; a new LOAD after release completes normally.
